// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver timed by a system-clock cycle counter.
// Bytes are presented on dout/dvalid with a valid/ready handshake. A low
// stop bit raises frame_err. A byte that completes while the previous one
// is still unaccepted raises overrun.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on the synchronised line
// START | timing half a bit to re-check the start bit at its centre
// DATA  | sampling eight data bits, LSB first, at each bit centre
// STOP  | sampling the stop bit at its centre, then delivering the byte
// BREAK | stop bit was low; wait for the line to return high
module uart_rx_core #(
  parameter int CLK_FREQ = 1000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       dready,
  output logic [7:0] dout,
  output logic       dvalid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          rx_meta;
  logic          rxs;

  // Two-flop synchroniser; it resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM and handshake. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      sh        <= 8'h00;
      dout      <= 8'h00;
      dvalid    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Acceptance; a delivery in the same cycle below overrides this.
      if (dvalid && dready) begin
        dvalid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxs) begin
              state <= S_DATA;
              idx   <= 3'd0;
            end else begin
              // Too short to be a start bit: treat it as a glitch.
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt == CPB_M1) begin
            cnt <= '0;
            sh  <= {rxs, sh[7:1]};
            if (idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (cnt == CPB_M1) begin
            cnt <= '0;
            if (rxs) begin
              // Leave at mid-stop so an immediately following start is caught.
              state <= S_IDLE;
              busy  <= 1'b0;
              if (!dvalid || dready) begin
                dout   <= sh;
                dvalid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_BREAK: begin
          cnt <= '0;
          if (rxs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core at default parameters (104 clocks per bit).
module tb_uart_rx_core;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       dready = 1'b0;
  logic [7:0] dout;
  logic       dvalid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] acc_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int dv_rise = 0;
  int busy_cyc = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic dv_prev = 1'b0;

  uart_rx_core dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .dready    (dready),
    .dout      (dout),
    .dvalid    (dvalid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: accepted bytes, pulses, busy length.
  always @(negedge clk) begin
    if (rst) begin
      if (dvalid && dready) acc_q.push_back(dout);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if ((frame_err && fe_prev) || (overrun && ov_prev)) wide_cnt++;
      if (dvalid && !dv_prev) dv_rise++;
      if (busy) busy_cyc++;
    end
    fe_prev = frame_err;
    ov_prev = overrun;
    dv_prev = dvalid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic pulse_ready();
    dready = 1'b1;
    tick(1);
    dready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_valid;
    logic [7:0] exp_dout;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fe0, ov0, dv0, base, b0;
    logic [7:0] tmp;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 8'hC3, 1};

    // Reset values
    tick(4);
    chk("rst_dout", dout, 8'h00);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick(10);

    // Single frame 0x0A with dready low; delivery timing window
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    tick(CPB);
    tmp = 8'h0A;
    for (int i = 0; i < 8; i++) begin
      rx = tmp[i];
      tick(CPB);
    end
    rx = 1'b1;
    tick(40);
    chk("t1_dvalid_not_early", dvalid, 0);
    tick(24);
    chk("t1_dvalid", dvalid, 1);
    chk("t1_dout", dout, 8'h0A);
    chk("t1_busy_low", busy, 0);
    tick(100);
    chk("t1_dvalid_held", dvalid, 1);
    pulse_ready();
    chk("t1_dvalid_accepted", dvalid, 0);
    chk("t1_dout_kept", dout, 8'h0A);
    chk("t1_frame_err", fe_cnt - fe0, 0);
    chk("t1_overrun", ov_cnt - ov0, 0);

    // Table of single frames
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt;
      send_frame(vecs[v].data, vecs[v].stop_bit);
      rx = 1'b1;
      tick(60);
      chk($sformatf("vec%0d_dvalid", v), dvalid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
      chk($sformatf("vec%0d_frame_err", v), fe_cnt - fe0, vecs[v].exp_fe);
      chk($sformatf("vec%0d_busy", v), busy, 0);
      if (vecs[v].exp_valid) begin
        pulse_ready();
        chk($sformatf("vec%0d_accept", v), dvalid, 0);
      end
    end

    // Ten back-to-back frames with dready held high
    fe0 = fe_cnt; ov0 = ov_cnt; dv0 = dv_rise;
    base = acc_q.size();
    dready = 1'b1;
    for (int i = 0; i < 10; i++) send_frame(8'h0A + 8'(i), 1'b1);
    tick(200);
    dready = 1'b0;
    chk("b2b_count", acc_q.size() - base, 10);
    chk("b2b_rises", dv_rise - dv0, 10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < acc_q.size())
        chk($sformatf("b2b_byte%0d", i), acc_q[base + i], 8'h0A + 8'(i));
      else
        chk($sformatf("b2b_byte%0d_missing", i), 0, 1);
    end
    chk("b2b_frame_err", fe_cnt - fe0, 0);
    chk("b2b_overrun", ov_cnt - ov0, 0);

    // Start-bit glitch: 20 clocks low
    b0 = busy_cyc; dv0 = dv_rise; fe0 = fe_cnt;
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(200);
    chk("glitch_busy_len", (busy_cyc - b0 >= 50) && (busy_cyc - b0 <= 54), 1);
    chk("glitch_no_dvalid", dv_rise - dv0, 0);
    chk("glitch_no_frame_err", fe_cnt - fe0, 0);
    chk("glitch_idle", busy, 0);

    // Framing error, long break, then a valid 0xA5
    fe0 = fe_cnt; ov0 = ov_cnt; dv0 = dv_rise;
    send_frame(8'h55, 1'b0);
    tick(196);
    chk("brk_busy", busy, 1);
    chk("brk_dvalid", dvalid, 0);
    rx = 1'b1;
    tick(50);
    send_frame(8'hA5, 1'b1);
    tick(60);
    chk("brk_frame_err", fe_cnt - fe0, 1);
    chk("brk_dvalid_rises", dv_rise - dv0, 1);
    chk("brk_dvalid_after", dvalid, 1);
    chk("brk_dout", dout, 8'hA5);
    chk("brk_overrun", ov_cnt - ov0, 0);
    pulse_ready();

    // Overrun: 0x11 then 0x22 with dready low
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(60);
    chk("ovr_dvalid", dvalid, 1);
    chk("ovr_dout", dout, 8'h11);
    chk("ovr_overrun", ov_cnt - ov0, 1);
    chk("ovr_frame_err", fe_cnt - fe0, 0);
    pulse_ready();
    chk("ovr_accept", dvalid, 0);
    chk("ovr_dout_kept", dout, 8'h11);

    // Reset during data bit 3 of 0x3C, then a full 0x3C
    send_frame(8'h3C, 1'b1);
    tick(60);
    pulse_ready();
    dv0 = dv_rise;
    tmp = 8'h3C;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = tmp[i];
      tick(CPB);
    end
    rx = tmp[3];
    tick(50);
    rst = 1'b0;
    tick(3);
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_dvalid", dvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_overrun", overrun, 0);
    rst = 1'b1;
    rx = 1'b1;
    tick(2 * CPB);
    chk("mid_rst_no_spurious", dv_rise - dv0, 0);
    send_frame(8'h3C, 1'b1);
    tick(60);
    chk("mid_rst_dvalid_after", dvalid, 1);
    chk("mid_rst_dout_after", dout, 8'h3C);
    chk("mid_rst_rises", dv_rise - dv0, 1);

    // Global pulse properties
    chk("pulse_exclusive", both_cnt, 0);
    chk("pulse_width", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
